// File: rtl/exp_taylor_engine_if.sv
// Request/result bundle between the accelerator controller and the e^x engine.
// Handshake: start is a level sampled only while the engine is idle; busy is high
// while an operation is in flight; done pulses for one cycle with result valid.
interface exp_taylor_engine_if;
  logic        start;
  logic [7:0]  x;
  logic [15:0] result;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output x,
    input  result,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  x,
    output result,
    output busy,
    output done
  );
endinterface

// File: rtl/exp_taylor_engine.sv
// Iterative Taylor-series e^x: term(n+1) = term(n) * x * coef(n), summed in Q2.14.
// Coefficients come from an external combinational ROM addressed by the iteration count.
module exp_taylor_engine #(
  parameter int unsigned ITER = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  exp_taylor_engine_if.slave  bus,
  output logic [3:0]          lut_addr,
  input  logic [15:0]         lut_data,
  output logic [2:0]          dbg_state
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MULX = 3'd2,
    S_MULC = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [3:0] LAST_N = 4'(ITER - 1);

  state_e      state_q, state_d;
  logic [7:0]  xr_q, xr_d;
  logic [15:0] term_q, term_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] p_q, p_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  n_q, n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [23:0] prod_x;
  logic [23:0] prod_c;
  logic [15:0] t;
  logic        unused_bits;

  // Both products keep bits [23:8]: a floor divide by 256, never rounded.
  assign prod_x      = {8'd0, term_q} * {16'd0, xr_q};
  assign prod_c      = {8'd0, p_q} * {16'd0, lut_data[7:0]};
  assign t           = prod_c[23:8];
  assign unused_bits = ^{lut_data[15:8], prod_x[7:0], prod_c[7:0]};

  always_comb begin
    state_d  = state_q;
    xr_d     = xr_q;
    term_d   = term_q;
    acc_d    = acc_q;
    p_d      = p_q;
    result_d = result_q;
    n_d      = n_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        xr_d    = bus.x;
        term_d  = 16'h4000;
        acc_d   = 16'h4000;
        n_d     = 4'd0;
        state_d = S_MULX;
      end
      S_MULX: begin
        p_d     = prod_x[23:8];
        state_d = S_MULC;
      end
      S_MULC: begin
        term_d = t;
        acc_d  = acc_q + t;
        if (n_q == LAST_N) begin
          result_d = acc_q + t;
          state_d  = S_DONE;
        end else begin
          n_d     = n_q + 4'd1;
          state_d = S_MULX;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the next-state decode.
    busy_d = (state_d == S_LOAD) || (state_d == S_MULX) || (state_d == S_MULC);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      xr_q     <= 8'd0;
      term_q   <= 16'd0;
      acc_q    <= 16'd0;
      p_q      <= 16'd0;
      result_q <= 16'd0;
      n_q      <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      xr_q     <= xr_d;
      term_q   <= term_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      result_q <= result_d;
      n_q      <= n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign lut_addr   = n_q;
  assign dbg_state  = state_q;
endmodule
